pht_update_ctrl: RTL and testbench

//  Sequences all traffic into the 2-bit pattern state table (PHT) of the branch predictor.
//  - Buffers resolved-branch updates from execute.
//  - Runs each update as a read-modify-write of the saturating counter.
//  - Runs a full-table clear sweep on request.
//  - Serves fetch-stage predictions, with a bypass for an in-flight write.
//  - Sits between the execute/fetch stages and the single-write-port PHT.

---
 rtl/bp_pkg.sv | 41 ++++
 rtl/pht_update_ctrl_if.sv | 28 ++
 rtl/bp_update_fifo.sv | 67 ++++++
 rtl/pht_update_ctrl.sv | 141 ++++++++++++++
 tb/tb_pht_update_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor PHT update path: counter encoding,
// queued update record, controller FSM states and the saturating-counter step.
package bp_pkg;

  localparam int PHT_DW = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_t;

  localparam pht_state_t PHT_INIT = WNT;

  typedef struct packed {
    logic [PHT_DW-1:0] idx;
    logic              taken;
    logic              pred;
  } bp_update_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    CLEAR
  } ctrl_state_t;

  // Two-bit counter step; holds at SNT and ST instead of wrapping.
  function automatic pht_state_t sat_next(input pht_state_t state, input logic taken);
    logic [1:0] s;
    s = state;
    if (taken && (s != 2'b11)) begin
      s = s + 2'd1;
    end else if (!taken && (s != 2'b00)) begin
      s = s - 2'd1;
    end
    return pht_state_t'(s);
  endfunction

endpackage

// File: rtl/pht_update_ctrl_if.sv
// Resolved-branch update handshake from execute into the PHT update controller.
interface pht_update_ctrl_if
  import bp_pkg::*;
#(
  parameter int DW = PHT_DW
);
  logic          upd_valid;
  logic          upd_ready;
  logic [DW-1:0] upd_idx;
  logic          upd_taken;
  logic          upd_pred;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_taken,
    output upd_pred,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_taken,
    input  upd_pred,
    output upd_ready
  );
endinterface

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO of pending PHT updates; flush drops everything queued.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int AW   = $clog2(QDEPTH),
  localparam int CNTW = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  bp_update_t      push_item,
  input  logic            pop,
  output bp_update_t      head,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);

  bp_update_t      mem [QDEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CNTW-1:0] count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == CNTW'(QDEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // An empty queue presents an all-zero head so downstream addresses idle at 0.
  assign head = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_item;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pht_update_ctrl.sv
// Sequences execute-stage updates and clear sweeps into the single-write-port PHT,
// and serves fetch predictions with a bypass for the write in flight.
module pht_update_ctrl
  import bp_pkg::*;
#(
  parameter int DW     = PHT_DW,
  parameter int QDEPTH = 4,
  parameter int CW     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pht_update_ctrl_if.slave        upd,
  input  logic                    clear_req,
  input  logic [DW-1:0]           pred_idx,
  output logic                    pred_taken,
  output logic                    busy,
  output logic [CW-1:0]           mispredicts,
  output logic                    pht_en,
  output logic [DW-1:0]           pht_waddr,
  output logic [1:0]              pht_next_state,
  input  logic [1:0]              pht_cur_state,
  output logic [DW-1:0]           pht_raddr,
  input  logic [1:0]              pht_pred_state
);

  localparam int CNTW = $clog2(QDEPTH) + 1;
  localparam logic [DW-1:0] SWEEP_LAST = '1;
  localparam logic [CW-1:0] MIS_MAX    = '1;

  ctrl_state_t     state_reg, state_next;
  logic [DW-1:0]   sweep_reg, sweep_next;
  logic [CW-1:0]   mis_reg, mis_next;

  bp_update_t      push_item;
  bp_update_t      head;
  logic [CNTW-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ready;
  logic            push;
  logic            pop;
  logic            more_after_pop;

  assign ready         = !fifo_full && !clear_req && (state_reg != CLEAR);
  assign upd.upd_ready = ready;
  assign push          = upd.upd_valid && ready;
  assign push_item     = '{idx: upd.upd_idx, taken: upd.upd_taken, pred: upd.upd_pred};

  bp_update_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear_req),
    .push      (push),
    .push_item (push_item),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A push landing alongside the pop keeps the pipeline going straight to READ.
  assign more_after_pop = (fifo_count > CNTW'(1)) || push;

  always_comb begin
    state_next     = state_reg;
    sweep_next     = sweep_reg;
    mis_next       = mis_reg;
    pop            = 1'b0;
    pht_en         = 1'b0;
    pht_waddr      = head.idx;
    pht_next_state = PHT_INIT;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = READ;
        end
      end
      READ: begin
        state_next = WRITE;
      end
      WRITE: begin
        pht_en         = 1'b1;
        pht_next_state = sat_next(pht_state_t'(pht_cur_state), head.taken);
        pop            = 1'b1;
        if ((head.pred != head.taken) && (mis_reg != MIS_MAX)) begin
          mis_next = mis_reg + 1'b1;
        end
        state_next = more_after_pop ? READ : IDLE;
      end
      CLEAR: begin
        pht_en     = 1'b1;
        pht_waddr  = sweep_reg;
        sweep_next = sweep_reg + 1'b1;
        if (sweep_reg == SWEEP_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (clear_req) begin
      state_next = CLEAR;
      sweep_next = '0;
      mis_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sweep_reg <= '0;
      mis_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
      mis_reg   <= mis_next;
    end
  end

  // The table read misses this cycle's falling-edge commit, so forward it here.
  always_comb begin
    pred_taken = pht_pred_state[1];
    if ((state_reg == WRITE) && (pht_waddr == pred_idx)) begin
      pred_taken = pht_next_state[1];
    end
    if ((state_reg == CLEAR) && (sweep_reg <= pred_idx)) begin
      pred_taken = 1'b0;
    end
  end

  assign busy        = (state_reg != IDLE) || !fifo_empty;
  assign mispredicts = mis_reg;
  assign pht_raddr   = pred_idx;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Directed bench for pht_update_ctrl: a behavioural PHT table, a table of
// single-update vectors, and hand-written burst/clear/bypass/reset sequences.
module tb_pht_update_ctrl;

  logic       clk;
  logic       reset;
  logic       clear_req;
  logic [3:0] pred_idx;
  logic       pred_taken;
  logic       busy;
  logic [1:0] mispredicts;
  logic       pht_en;
  logic [3:0] pht_waddr;
  logic [1:0] pht_next_state;
  logic [1:0] pht_cur_state;
  logic [3:0] pht_raddr;
  logic [1:0] pht_pred_state;

  pht_update_ctrl_if #(.DW(4)) upd_if ();

  pht_update_ctrl #(
    .DW     (4),
    .QDEPTH (4),
    .CW     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .upd            (upd_if.slave),
    .clear_req      (clear_req),
    .pred_idx       (pred_idx),
    .pred_taken     (pred_taken),
    .busy           (busy),
    .mispredicts    (mispredicts),
    .pht_en         (pht_en),
    .pht_waddr      (pht_waddr),
    .pht_next_state (pht_next_state),
    .pht_cur_state  (pht_cur_state),
    .pht_raddr      (pht_raddr),
    .pht_pred_state (pht_pred_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PHT: commits on the falling edge, registered read of pht_waddr.
  logic [1:0] pht [16];
  logic       preset_all;
  logic       preset_req;
  logic [3:0] preset_idx;
  logic [1:0] preset_val;

  always @(negedge clk) begin
    if (preset_all) begin
      for (int i = 0; i < 16; i++) pht[i] <= 2'b01;
    end else if (preset_req) begin
      pht[preset_idx] <= preset_val;
    end else if (pht_en) begin
      pht[pht_waddr] <= pht_next_state;
    end
  end

  always @(posedge clk) pht_cur_state <= pht[pht_waddr];
  assign pht_pred_state = pht[pht_raddr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [3:0] idx, input logic [1:0] val);
    preset_idx = idx;
    preset_val = val;
    preset_req = 1'b1;
    tick();
    preset_req = 1'b0;
  endtask

  task automatic push_one(input logic [3:0] idx, input logic t, input logic p, output int c0);
    upd_if.upd_valid = 1'b1;
    upd_if.upd_idx   = idx;
    upd_if.upd_taken = t;
    upd_if.upd_pred  = p;
    c0 = cyc;
    check("ready_before_push", upd_if.upd_ready, 1);
    tick();
    upd_if.upd_valid = 1'b0;
  endtask

  typedef struct packed {
    logic       do_preset;
    logic [1:0] preset_val;
    logic [3:0] idx;
    logic       taken;
    logic       pred;
    logic [1:0] exp_next;
    logic [1:0] exp_mis;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  typedef struct packed {
    logic [3:0] idx;
    logic       taken;
    logic [1:0] exp_next;
  } burst_t;

  burst_t bt [5];

  int         c0;
  int         nw;
  int         wc;
  logic [3:0] wa;
  logic [1:0] wd;

  initial begin
    vt[0] = '{1'b0, 2'b00, 4'd3, 1'b1, 1'b1, 2'b10, 2'd0};
    vt[1] = '{1'b1, 2'b11, 4'd9, 1'b1, 1'b1, 2'b11, 2'd0};
    vt[2] = '{1'b0, 2'b00, 4'd9, 1'b1, 1'b1, 2'b11, 2'd0};
    vt[3] = '{1'b0, 2'b00, 4'd9, 1'b1, 1'b1, 2'b11, 2'd0};
    vt[4] = '{1'b1, 2'b00, 4'd2, 1'b0, 1'b0, 2'b00, 2'd0};
    vt[5] = '{1'b0, 2'b00, 4'd2, 1'b0, 1'b0, 2'b00, 2'd0};
    vt[6] = '{1'b0, 2'b00, 4'd5, 1'b0, 1'b1, 2'b00, 2'd1};
    vt[7] = '{1'b1, 2'b10, 4'd6, 1'b1, 1'b0, 2'b11, 2'd2};
    vt[8] = '{1'b0, 2'b00, 4'd3, 1'b0, 1'b0, 2'b01, 2'd2};
    vt[9] = '{1'b0, 2'b00, 4'd3, 1'b1, 1'b1, 2'b10, 2'd2};

    bt[0] = '{4'd1,  1'b1, 2'b10};
    bt[1] = '{4'd2,  1'b0, 2'b01};
    bt[2] = '{4'd4,  1'b1, 2'b11};
    bt[3] = '{4'd8,  1'b1, 2'b01};
    bt[4] = '{4'd15, 1'b0, 2'b00};

    reset            = 1'b0;
    clear_req        = 1'b0;
    pred_idx         = '0;
    preset_all       = 1'b0;
    preset_req       = 1'b0;
    preset_idx       = '0;
    preset_val       = '0;
    upd_if.upd_valid = 1'b0;
    upd_if.upd_idx   = '0;
    upd_if.upd_taken = 1'b0;
    upd_if.upd_pred  = 1'b0;

    // ---------------- reset state
    #1 reset = 1'b1;
    #3;
    check("rst_pht_en", pht_en, 0);
    check("rst_waddr", pht_waddr, 0);
    check("rst_next_state", pht_next_state, 2'b01);
    check("rst_busy", busy, 0);
    check("rst_upd_ready", upd_if.upd_ready, 1);
    check("rst_mispredicts", mispredicts, 0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    preset_all = 1'b1;
    tick();
    preset_all = 1'b0;
    $display("[TB] reset checked, table preset to WNT");

    // ---------------- single-update vectors
    for (int v = 0; v < NV; v++) begin
      if (vt[v].do_preset) preset(vt[v].idx, vt[v].preset_val);
      pred_idx = vt[v].idx;
      push_one(vt[v].idx, vt[v].taken, vt[v].pred, c0);
      nw = 0; wc = 0; wa = '0; wd = '0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (pht_en) begin
          nw++;
          if (nw == 1) begin
            wc = cyc; wa = pht_waddr; wd = pht_next_state;
          end
        end
      end
      check("vec_write_count", nw, 1);
      check("vec_write_cycle", wc - c0, 3);
      check("vec_waddr", wa, vt[v].idx);
      check("vec_next_state", wd, vt[v].exp_next);
      check("vec_mispredicts", mispredicts, vt[v].exp_mis);
      check("vec_pred_after", pred_taken, vt[v].exp_next[1]);
      $display("[TB] vec %0d idx=%0d taken=%0d pred=%0d -> wrote %b at +%0d, mispredicts=%0d",
               v, vt[v].idx, vt[v].taken, vt[v].pred, wd, wc - c0, mispredicts);
    end

    // ---------------- 5 back-to-back updates into a 4-deep queue
    preset(4'd2, 2'b10);
    preset(4'd4, 2'b11);
    preset(4'd8, 2'b00);
    begin
      int   pushed;
      int   guard;
      logic acc;
      int   j;
      int   prev_w;
      int   ready_low;
      logic busy_chk;
      pushed = 0; guard = 0; j = 0; prev_w = 0; ready_low = 0; busy_chk = 1'b0;
      fork
        begin
          while ((pushed < 5) && (guard < 50)) begin
            upd_if.upd_valid = 1'b1;
            upd_if.upd_idx   = bt[pushed].idx;
            upd_if.upd_taken = bt[pushed].taken;
            upd_if.upd_pred  = bt[pushed].taken;
            acc = upd_if.upd_ready;
            tick();
            if (acc) pushed++;
            guard++;
          end
          upd_if.upd_valid = 1'b0;
        end
        begin
          for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!upd_if.upd_ready) ready_low++;
            if (busy_chk) begin
              check("burst_busy_after_last", busy, 0);
              busy_chk = 1'b0;
            end
            if (pht_en && (j < 5)) begin
              check("burst_waddr", pht_waddr, bt[j].idx);
              check("burst_next_state", pht_next_state, bt[j].exp_next);
              if (j > 0) check("burst_spacing", cyc - prev_w, 2);
              $display("[TB] burst write %0d addr=%0d data=%b", j, pht_waddr, pht_next_state);
              prev_w = cyc;
              j++;
              if (j == 5) begin
                check("burst_busy_at_last", busy, 1);
                busy_chk = 1'b1;
              end
            end
          end
        end
      join
      check("burst_pushed", pushed, 5);
      check("burst_writes", j, 5);
      check("burst_ready_dropped", (ready_low > 0) ? 1 : 0, 1);
      check("burst_mispredicts", mispredicts, 2);
    end

    // ---------------- clear_req with 3 updates queued
    preset(4'd15, 2'b11);
    pred_idx = 4'd15;
    upd_if.upd_valid = 1'b1;
    upd_if.upd_idx = 4'd10; upd_if.upd_taken = 1'b1; upd_if.upd_pred = 1'b0; tick();
    upd_if.upd_idx = 4'd11; upd_if.upd_taken = 1'b0; upd_if.upd_pred = 1'b1; tick();
    upd_if.upd_idx = 4'd13; upd_if.upd_taken = 1'b1; upd_if.upd_pred = 1'b0; tick();
    clear_req = 1'b1;
    upd_if.upd_idx = 4'd14;
    #1;
    check("clear_ready_in_req_cycle", upd_if.upd_ready, 0);
    tick();
    clear_req = 1'b0;
    upd_if.upd_valid = 1'b0;
    c0 = cyc;
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) check("clear_pred_masked", pred_taken, 0);
      if (k < 16) check("clear_ready_low", upd_if.upd_ready, 0);
      if (pht_en) begin
        check("clear_addr", pht_waddr, nw);
        check("clear_data", pht_next_state, 2'b01);
        check("clear_cycle", cyc - c0, nw);
        nw++;
      end
    end
    check("clear_write_count", nw, 16);
    check("clear_mispredicts", mispredicts, 0);
    check("clear_ready_after", upd_if.upd_ready, 1);
    check("clear_busy_after", busy, 0);
    $display("[TB] clear sweep: %0d writes, mispredicts=%0d", nw, mispredicts);

    // ---------------- bypass of in-flight write to prediction
    pred_idx = 4'd7;
    push_one(4'd7, 1'b1, 1'b1, c0);
    tick();
    check("bypass_pred_before", pred_taken, 0);
    tick();
    check("bypass_write_active", pht_en, 1);
    check("bypass_pred_in_write", pred_taken, 1);
    tick(); tick();
    check("bypass_pred_after", pred_taken, 1);
    $display("[TB] bypass idx=7 WNT->WT, pred_taken forwarded");

    // ---------------- mispredict saturation (CW=2)
    begin
      int   pushed;
      int   guard;
      logic acc;
      pushed = 0; guard = 0;
      while ((pushed < 5) && (guard < 60)) begin
        upd_if.upd_valid = 1'b1;
        upd_if.upd_idx   = 4'(pushed);
        upd_if.upd_taken = 1'b1;
        upd_if.upd_pred  = 1'b0;
        acc = upd_if.upd_ready;
        tick();
        if (acc) pushed++;
        guard++;
      end
      upd_if.upd_valid = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("sat_pushed", pushed, 5);
      check("sat_mispredicts", mispredicts, 3);
      check("sat_idle", busy, 0);
      $display("[TB] 5 mispredicted updates -> mispredicts=%0d", mispredicts);
    end

    // ---------------- asynchronous reset in the middle of WRITE
    push_one(4'd8, 1'b1, 1'b0, c0);
    tick();
    tick();
    check("rstmid_in_write", pht_en, 1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_pht_en", pht_en, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_mispredicts", mispredicts, 0);
    check("rstmid_ready", upd_if.upd_ready, 1);
    check("rstmid_waddr", pht_waddr, 0);
    check("rstmid_next_state", pht_next_state, 2'b01);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstmid_no_write", pht_en, 0);
    end
    $display("[TB] async reset mid-WRITE handled");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
